// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: read-priority arbiter between a capture writer and a display reader
// sharing one single-port synchronous RAM, with a bounded write-starvation window.
module frame_buffer_arbiter #(
  parameter int AddrWidth = 20,
  parameter int DataWidth = 24,
  parameter int BufferSize = 24000,
  parameter int MaxReadBurst = 4,
  parameter logic [DataWidth-1:0] FillValue = 24'hFFFFFF
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 WrValid,
  input  logic [AddrWidth-1:0] WrAddr,
  input  logic [DataWidth-1:0] WrData,
  output logic                 WrReady,
  input  logic                 RdValid,
  input  logic [AddrWidth-1:0] RdAddr,
  output logic                 RdReady,
  output logic                 RdDataValid,
  output logic [DataWidth-1:0] RdData,
  output logic                 MemEn,
  output logic                 MemWE,
  output logic [AddrWidth-1:0] MemAddr,
  output logic [DataWidth-1:0] MemDIn,
  input  logic [DataWidth-1:0] MemDOut,
  output logic [15:0]          DropCount
);
  typedef enum logic {ARB_READ, ARB_WRITE} state_t;
  localparam logic [AddrWidth-1:0] Limit = AddrWidth'(BufferSize);
  localparam logic [2:0] MaxB = 3'(MaxReadBurst);
  state_t state;
  logic run, rd_blk, rd_in, wr_in;
  logic [2:0] rd_burst;
  logic p1_v, p1_o, p2_v, p2_o;
  always_comb begin
    rd_blk = WrValid && rd_burst == MaxB;
    rd_in = RdAddr < Limit;
    wr_in = WrAddr < Limit;
    RdReady = run && state == ARB_READ && RdValid && !rd_blk;
    WrReady = run && WrValid && (state == ARB_WRITE || !RdReady);
  end
  // run delays the first grant to the second edge after reset release
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      run <= 1'b0;
      state <= ARB_READ;
      rd_burst <= '0;
      MemEn <= 1'b0;
      MemWE <= 1'b0;
      MemAddr <= '0;
      MemDIn <= '0;
      p1_v <= 1'b0;
      p1_o <= 1'b0;
      p2_v <= 1'b0;
      p2_o <= 1'b0;
      RdDataValid <= 1'b0;
      RdData <= '0;
      DropCount <= '0;
    end else begin
      run <= 1'b1;
      state <= (state == ARB_READ && rd_blk && !WrReady) ? ARB_WRITE : ARB_READ;
      rd_burst <= (WrReady || !WrValid) ? '0 : (RdReady && rd_burst != MaxB) ? rd_burst + 3'd1 : rd_burst;
      MemEn <= (RdReady && rd_in) || (WrReady && wr_in);
      MemWE <= WrReady && wr_in;
      if (RdReady && rd_in) MemAddr <= RdAddr;
      else if (WrReady && wr_in) begin
        MemAddr <= WrAddr;
        MemDIn <= WrData;
      end
      // out-of-range reads ride the same pipeline so responses stay in grant order
      p1_v <= RdReady;
      p1_o <= !rd_in;
      p2_v <= p1_v;
      p2_o <= p1_o;
      RdDataValid <= p2_v;
      if (p2_v) RdData <= p2_o ? FillValue : MemDOut;
      if (WrReady && !wr_in && DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
    end
  end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed stimulus with a read-response scoreboard and a RAM model.
module tb_frame_buffer_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0, rd_valid = 1'b0;
  logic [19:0] wr_addr = '0, rd_addr = '0;
  logic [23:0] wr_data = '0;
  logic wr_ready, rd_ready, rd_data_valid, mem_en, mem_we;
  logic [23:0] rd_data, mem_din;
  logic [23:0] mem_dout = '0;
  logic [19:0] mem_addr;
  logic [15:0] drop_count;
  logic [23:0] mem [0:23999];
  logic [23:0] exp_q[$];
  int cyc_q[$];
  int cyc = 0;
  int checks = 0;
  int fails = 0;

  frame_buffer_arbiter dut (
    .Clock(clk), .Reset(rst_n),
    .WrValid(wr_valid), .WrAddr(wr_addr), .WrData(wr_data), .WrReady(wr_ready),
    .RdValid(rd_valid), .RdAddr(rd_addr), .RdReady(rd_ready),
    .RdDataValid(rd_data_valid), .RdData(rd_data),
    .MemEn(mem_en), .MemWE(mem_we), .MemAddr(mem_addr), .MemDIn(mem_din),
    .MemDOut(mem_dout), .DropCount(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial for (int i = 0; i < 24000; i++) mem[i] = '0;
  always @(posedge clk)
    if (mem_en && mem_addr < 20'd24000) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      else mem_dout <= mem[mem_addr];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rd_data_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rd_data_valid", 1, 0);
      else begin
        chk("rd_data", rd_data, exp_q.pop_front());
        chk("rd_latency", cyc, cyc_q.pop_front());
      end
    end
    if (rd_ready || wr_ready) chk("single_grant", {31'd0, rd_ready && wr_ready}, 0);
    if (mem_en && mem_we) chk("no_oor_ram_write", {31'd0, mem_addr >= 20'd24000}, 0);
  end

  task automatic read_op(input logic [19:0] a, input logic [23:0] e);
    bit got = 0;
    rd_valid = 1'b1;
    rd_addr = a;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rd_ready) begin
        got = 1;
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 3);
      end
      @(posedge clk); #1;
    end
    rd_valid = 1'b0;
    if (!got) chk("rd_grant_timeout", 0, 1);
    else if (a >= 20'd24000) chk("oor_rd_no_mem_en", {31'd0, mem_en}, 0);
    else chk("rd_mem_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, a});
  endtask

  task automatic write_op(input logic [19:0] a, input logic [23:0] d);
    bit got = 0;
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = wr_ready;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    if (!got) chk("wr_grant_timeout", 0, 1);
    else begin
      chk("wr_mem_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, a});
      chk("wr_mem_din", mem_din, d);
    end
  endtask

  initial begin
    logic [14:0] pat = 15'b100001000010000;
    #100_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] pat;
    pat = 15'b100001000010000;
    rd_valid = 1'b1;
    rd_addr = 20'd7;
    wr_valid = 1'b1;
    wr_addr = 20'd3;
    repeat (3) @(negedge clk);
    chk("rst_ready", {rd_ready, wr_ready}, 0);
    chk("rst_mem", {mem_en, mem_we, mem_addr}, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_rd", {rd_data_valid, rd_data}, 0);
    chk("rst_drop", drop_count, 0);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    #1 chk("release_no_grant_first_edge", {31'd0, rd_ready}, 0);
    @(posedge clk); #1;
    chk("release_ready_second_edge", {31'd0, rd_ready}, 1);
    read_op(20'd7, 24'h0);

    write_op(20'd100, 24'h123456);
    read_op(20'd100, 24'h123456);

    // simultaneous read and write to addr 5 with an empty burst: read wins, sees old data
    rd_valid = 1'b1; rd_addr = 20'd5;
    wr_valid = 1'b1; wr_addr = 20'd5; wr_data = 24'hABCDEF;
    @(negedge clk);
    chk("same_cycle_read_first", {rd_ready, wr_ready}, 2'b10);
    if (rd_ready) begin exp_q.push_back(24'h0); cyc_q.push_back(cyc + 3); end
    @(posedge clk); #1;
    rd_valid = 1'b0;
    @(negedge clk);
    chk("same_cycle_write_next", {31'd0, wr_ready}, 1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    read_op(20'd5, 24'hABCDEF);

    read_op(20'd24000, 24'hFFFFFF);
    read_op(20'd24001, 24'hFFFFFF);

    rd_valid = 1'b1; rd_addr = 20'd10;
    wr_valid = 1'b1; wr_addr = 20'd11; wr_data = 24'h0000AA;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk($sformatf("burst_pattern_%0d", i), {rd_ready, wr_ready}, {!pat[i], pat[i]});
      if (rd_ready) begin exp_q.push_back(24'h0); cyc_q.push_back(cyc + 3); end
      @(posedge clk); #1;
    end
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    repeat (4) @(posedge clk); #1;

    wr_valid = 1'b1; wr_addr = 20'd30000; wr_data = 24'h555555;
    repeat (100) @(posedge clk); #1;
    chk("drop_count_100", drop_count, 100);
    repeat (65500) @(posedge clk); #1;
    chk("drop_count_sat", drop_count, 16'hFFFF);
    repeat (10) @(posedge clk); #1;
    chk("drop_count_hold", drop_count, 16'hFFFF);
    wr_valid = 1'b0;

    read_op(20'd100, 24'h123456);
    read_op(20'd100, 24'h123456);
    read_op(20'd100, 24'h123456);
    rd_valid = 1'b1;
    rst_n = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    #1;
    chk("midrst_rd", {rd_data_valid, rd_data}, 0);
    chk("midrst_mem", {mem_en, mem_we, mem_addr}, 0);
    chk("midrst_din", mem_din, 0);
    chk("midrst_drop", drop_count, 0);
    chk("midrst_ready", {rd_ready, wr_ready}, 0);
    rd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    read_op(20'd100, 24'h123456);
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/frame_buffer_arbiter.md
FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

Interface
REQ-001 SHALL have parameters: AddrWidth, 20, pixel address width; DataWidth, 24, RGB pixel width; BufferSize, 24000, number of valid pixel locations; MaxReadBurst, 4, max consecutive read grants while a write waits; FillValue, 24'hFFFFFF, data returned for out-of-range reads.
REQ-002 SHALL have ports: Clock  in  1  sole clock; rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 WrValid  in  1  capture write request; WrAddr  in  AddrWidth; WrData  in  DataWidth.
REQ-005 WrReady  out  1  write accepted this cycle.
REQ-006 RdValid  in  1  display read request; RdAddr  in  AddrWidth.
REQ-007 RdReady  out  1  read accepted this cycle.
REQ-008 RdDataValid  out  1  one-cycle strobe; RdData  out  DataWidth  returned pixel.
REQ-009 MemEn  out  1; MemWE  out  1; MemAddr  out  AddrWidth; MemDIn  out  DataWidth: single-port synchronous RAM command, one read-latency cycle.
REQ-010 MemDOut  in  DataWidth  RAM read data, valid the cycle after MemEn&!MemWE is sampled.
REQ-011 DropCount  out  16  saturating count of out-of-range writes.

Function
REQ-012 Handshake: transfer occurs when Valid&Ready in the same cycle; Ready is combinational from Valid and arbiter state; at most one of RdReady/WrReady high per cycle.
REQ-013 FSM states ARB_READ (read priority) and ARB_WRITE (forced write turn); a 3-bit burst counter RdBurst.
REQ-014 ARB_READ: if RdValid and not (WrValid and RdBurst==MaxReadBurst) -> grant read; else if WrValid -> grant write; else no grant.
REQ-015 RdBurst: +1 on each read grant while WrValid high; cleared on write grant or when WrValid low; saturates at MaxReadBurst.
REQ-016 ARB_READ -> ARB_WRITE when RdBurst==MaxReadBurst and WrValid high and no grant was made by REQ-014 to read; ARB_WRITE grants write if WrValid, clears RdBurst, returns to ARB_READ next cycle unconditionally.
REQ-017 Write starvation bound: a continuously asserted WrValid SHALL be granted within MaxReadBurst+1 cycles.
REQ-018 Granted in-range access (addr < BufferSize) in cycle N: MemEn=1, MemWE=write, MemAddr, MemDIn registered, visible cycle N+1; otherwise MemEn=0, MemWE=0.
REQ-019 Read latency: RdDataValid=1 and RdData=registered MemDOut in cycle N+3 for a read granted in cycle N; fixed, no bubbles.
REQ-020 Out-of-range read (RdAddr >= BufferSize): accepted, no RAM access, RdDataValid in cycle N+3 with RdData=FillValue; response order equals grant order.
REQ-021 Out-of-range write: accepted (WrReady=1), RAM untouched, DropCount +1, saturating at 16'hFFFF.
REQ-022 Ordering: accesses reach RAM in grant order; a read granted after a write to the same address returns the new data; a read granted before returns the old data.
REQ-023 Back-to-back grants every cycle SHALL be supported; throughput one access per cycle.

Reset
REQ-024 Reset low: state ARB_READ, RdBurst=0, MemEn=0, MemWE=0, MemAddr=0, MemDIn=0, RdDataValid=0, RdData=0, DropCount=0; WrReady/RdReady=0 while Reset low.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight reads (no RdDataValid after release for pre-reset grants); release is synchronized so the first grant is possible on the second rising edge after deassertion.

Verification
REQ-026 Write addr 100 data 24'h123456, then read addr 100 -> MemWE pulse with MemAddr=100; RdDataValid 3 cycles after read grant with RdData=24'h123456.
REQ-027 RdValid and WrValid held high continuously -> grant pattern 4 reads, 1 write, repeating; RdBurst never exceeds 4.
REQ-028 Read addr 24000 and 24001 back-to-back -> no MemEn; two RdDataValid strobes, RdData=24'hFFFFFF, in cycles N+3 and N+4.
REQ-029 70000 writes to addr 30000 -> RAM never written, DropCount=16'hFFFF and holds.
REQ-030 Three reads in flight, Reset pulsed low 1 cycle -> all outputs at reset values, no RdDataValid afterwards until a new read is granted.
REQ-031 Same-cycle RdValid/WrValid to addr 5 (old 24'h0, new 24'hABCDEF), RdBurst=0 -> read granted first returns 24'h0; next read to addr 5 returns 24'hABCDEF.
